ee214_demux4_dist: RTL and testbench

EE214_DEMUX4_DIST -- requirements
Module: ee214_demux4_dist

---
 rtl/ee214_demux_pkg.sv | 16 +
 rtl/ee214_demux_lane.sv | 38 +++
 rtl/ee214_demux4_dist.sv | 61 ++++++
 tb/tb_ee214_demux4_dist.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ee214_demux_pkg.sv
// Shared constants and types for the 4-lane byte distributor.
package ee214_demux_pkg;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int PTR_W = 2;

  typedef logic [PTR_W-1:0] lane_idx_t;
  typedef logic [DW-1:0]    byte_t;

  // Pointer advance; wraps naturally at LANES since LANES == 2**PTR_W.
  function automatic lane_idx_t next_ptr(input lane_idx_t p);
    return p + lane_idx_t'(1);
  endfunction

endpackage

// File: rtl/ee214_demux_lane.sv
// One distributor lane: data register plus valid flag, loaded by the
// distributor and released by its consumer. Macro DEMUX_CLEAR_ON_ACK_EN zeroes data on release.
module ee214_demux_lane
  import ee214_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  ack,
  input  byte_t d,
  output byte_t q,
  output logic  valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

  // A load in the same cycle as an ack always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
`ifdef DEMUX_CLEAR_ON_ACK_EN
    end else if (ack && valid) begin
      q <= '0;
`endif
    end
  end

endmodule

// File: rtl/ee214_demux4_dist.sv
// Byte distributor to four handshaked lanes, direct (sel) or round-robin target.
// Optional macro DEMUX_CLEAR_ON_ACK_EN zeroes lane data when a lane is consumed.
module ee214_demux4_dist
  import ee214_demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [PTR_W-1:0] sel,
  input  logic             rr_mode,
  output logic [DW-1:0]    O0,
  output logic [DW-1:0]    O1,
  output logic [DW-1:0]    O2,
  output logic [DW-1:0]    O3,
  output logic [LANES-1:0] lane_valid,
  input  logic [LANES-1:0] lane_ack,
  output logic [PTR_W-1:0] rr_ptr
);

  lane_idx_t        tgt;
  logic             accept;
  logic [LANES-1:0] load;
  byte_t            lane_q [LANES];

  assign tgt       = rr_mode ? rr_ptr : sel;
  assign din_ready = ~lane_valid[tgt] | lane_ack[tgt];
  assign accept    = din_valid & din_ready;

  always_comb begin
    load = '0;
    load[tgt] = accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && rr_mode) begin
      rr_ptr <= next_ptr(rr_ptr);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ee214_demux_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .ack   (lane_ack[k]),
      .d     (din),
      .q     (lane_q[k]),
      .valid (lane_valid[k])
    );
  end

  assign O0 = lane_q[0];
  assign O1 = lane_q[1];
  assign O2 = lane_q[2];
  assign O3 = lane_q[3];

endmodule

// File: tb/tb_ee214_demux4_dist.sv
// Directed bench for ee214_demux4_dist; expectations follow DEMUX_CLEAR_ON_ACK_EN.
module tb_ee214_demux4_dist;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] sel;
  logic       rr_mode;
  logic [7:0] O0, O1, O2, O3;
  logic [3:0] lane_valid;
  logic [3:0] lane_ack;
  logic [1:0] rr_ptr;

  int tests = 0;
  int fails = 0;

  ee214_demux4_dist dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sel        (sel),
    .rr_mode    (rr_mode),
    .O0         (O0),
    .O1         (O1),
    .O2         (O2),
    .O3         (O3),
    .lane_valid (lane_valid),
    .lane_ack   (lane_ack),
    .rr_ptr     (rr_ptr)
  );

  always #5 clk = ~clk;

`ifdef DEMUX_CLEAR_ON_ACK_EN
  localparam logic [7:0] O2_AFTER_ACK = 8'h00;
  localparam logic [7:0] O3_AFTER_ACK = 8'h00;
`else
  localparam logic [7:0] O2_AFTER_ACK = 8'hA5;
  localparam logic [7:0] O3_AFTER_ACK = 8'h44;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sel = '0; rr_mode = 1'b0; lane_ack = '0;
    #1;
    chk("rst_O0", 32'(O0), 32'h00);
    chk("rst_valid", 32'(lane_valid), 32'h0);
    chk("rst_ptr", 32'(rr_ptr), 32'h0);
    step(); step();
    rst = 1'b0;

    // direct write to lane 2
    sel = 2'd2; din = 8'hA5; din_valid = 1'b1;
    #1 chk("direct_ready", 32'(din_ready), 32'h1);
    step();
    din_valid = 1'b0;
    chk("direct_O2", 32'(O2), 32'hA5);
    chk("direct_valid", 32'(lane_valid), 32'b0100);
    chk("direct_O0", 32'(O0), 32'h00);
    chk("direct_ptr", 32'(rr_ptr), 32'h0);

    // consume lane 2 alone
    lane_ack = 4'b0100;
    step();
    lane_ack = '0;
    chk("ack2_valid", 32'(lane_valid), 32'b0000);
    chk("ack2_O2", 32'(O2), 32'(O2_AFTER_ACK));

    // ack on empty lane 3 is ignored
    lane_ack = 4'b1000;
    step();
    lane_ack = '0;
    chk("ack_empty_valid", 32'(lane_valid), 32'b0000);
    chk("ack_empty_O3", 32'(O3), 32'h00);

    // round robin fill
    rr_mode = 1'b1; din_valid = 1'b1;
    din = 8'h11; step(); chk("rr_ptr1", 32'(rr_ptr), 32'h1);
    din = 8'h22; step(); chk("rr_ptr2", 32'(rr_ptr), 32'h2);
    din = 8'h33; step(); chk("rr_ptr3", 32'(rr_ptr), 32'h3);
    din = 8'h44; step(); chk("rr_ptr0", 32'(rr_ptr), 32'h0);
    chk("rr_data", {O0, O1, O2, O3}, 32'h11223344);
    chk("rr_full", 32'(lane_valid), 32'b1111);

    // lane 0 consumed while 8'h55 arrives on it
    din = 8'h55; lane_ack = 4'b0001;
    #1 chk("rr_ack_ready", 32'(din_ready), 32'h1);
    step();
    lane_ack = '0;
    chk("rr_O0_55", 32'(O0), 32'h55);
    chk("rr_ptr_wrap", 32'(rr_ptr), 32'h1);
    chk("rr_full2", 32'(lane_valid), 32'b1111);

    // backpressure: all full, no ack, hold 5 cycles
    din = 8'h66;
    #1 chk("bp_ready", 32'(din_ready), 32'h0);
    repeat (5) step();
    chk("bp_data", {O0, O1, O2, O3}, 32'h55223344);
    chk("bp_ptr", 32'(rr_ptr), 32'h1);
    chk("bp_valid", 32'(lane_valid), 32'b1111);

    // mode switch leaves state alone; direct target full as well
    rr_mode = 1'b0; sel = 2'd0;
    #1 chk("bp_direct_ready", 32'(din_ready), 32'h0);
    step();
    chk("mode_sw_ptr", 32'(rr_ptr), 32'h1);
    chk("mode_sw_data", {O0, O1, O2, O3}, 32'h55223344);

    // simultaneous ack and write on lane 1
    rr_mode = 1'b1; din = 8'h77; lane_ack = 4'b0010;
    #1 chk("simul_ready", 32'(din_ready), 32'h1);
    step();
    lane_ack = '0; din_valid = 1'b0;
    chk("simul_O1", 32'(O1), 32'h77);
    chk("simul_valid", 32'(lane_valid), 32'b1111);
    chk("simul_ptr", 32'(rr_ptr), 32'h2);

    // consume lane 3, then direct-mode write does not move the pointer
    lane_ack = 4'b1000;
    step();
    lane_ack = '0;
    chk("ack3_valid", 32'(lane_valid), 32'b0111);
    chk("ack3_O3", 32'(O3), 32'(O3_AFTER_ACK));
    rr_mode = 1'b0; sel = 2'd3; din = 8'h88; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("direct3_O3", 32'(O3), 32'h88);
    chk("direct3_ptr", 32'(rr_ptr), 32'h2);
    chk("direct3_valid", 32'(lane_valid), 32'b1111);

    // asynchronous reset mid-transfer
    rr_mode = 1'b1; din = 8'h9A; din_valid = 1'b1; lane_ack = 4'b0100;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_data", {O0, O1, O2, O3}, 32'h0);
    chk("mid_rst_valid", 32'(lane_valid), 32'h0);
    chk("mid_rst_ptr", 32'(rr_ptr), 32'h0);
    step();
    rst = 1'b0; lane_ack = '0; din = 8'h99;
    step();
    din_valid = 1'b0;
    chk("post_rst_O0", 32'(O0), 32'h99);
    chk("post_rst_ptr", 32'(rr_ptr), 32'h1);
    chk("post_rst_valid", 32'(lane_valid), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
